sign_text_emitter: RTL and testbench



---
 rtl/sign_text_pkg.sv | 22 ++
 rtl/sign_char_fifo.sv | 63 ++++++
 rtl/sign_text_emitter.sv | 111 +++++++++++
 tb/tb_sign_text_emitter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_text_pkg.sv
// Shared constants, debounce state encoding and the
// sign-code to ASCII mapping for the sign text emitter.
package sign_text_pkg;

  localparam logic [3:0] NO_SIGN = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  function automatic logic [7:0] sign_to_ascii(
    input logic [3:0] s
  );
    logic [7:0] v;
    v = {4'h0, s};
    if (s < 4'd10) return 8'h30 + v;
    return 8'h37 + v;
  endfunction

endpackage

// File: rtl/sign_char_fifo.sv
// Synchronous character FIFO with registered storage,
// async active-low reset and synchronous clear.
module sign_char_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sign_text_emitter.sv
// Debounces per-frame sign codes, suppresses repeats and
// streams committed signs as ASCII through a small FIFO.
module sign_text_emitter
  import sign_text_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int FIFO_DEPTH    = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    sign_value,
  input  logic          sign_valid,
  input  logic          clear,
  output logic [7:0]    char_data,
  output logic          char_valid,
  input  logic          char_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] last_q, last_d;
  logic [3:0] run_cnt;
  logic       match;
  logic       commit;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       ovf_q;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    commit  = 1'b0;
    match   = (sign_value == cand_q);
    run_cnt = match ? cnt_q + 4'd1 : 4'd1;
    // a locked sign simply holds while it keeps repeating
    if (sign_valid && !(state_q == LOCKED && match)) begin
      cand_d = sign_value;
      cnt_d  = run_cnt;
      if (run_cnt == SF) begin
        commit  = 1'b1;
        state_d = LOCKED;
        last_d  = sign_value;
      end else begin
        state_d = TRACK;
      end
    end
  end

  assign push = commit && !clear &&
                (sign_value != NO_SIGN) &&
                (sign_value != last_q);
  assign pop  = char_valid && char_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= NO_SIGN;
      cnt_q   <= '0;
      last_q  <= NO_SIGN;
    end else if (clear) begin
      state_q <= IDLE;
      cand_q  <= NO_SIGN;
      cnt_q   <= '0;
      last_q  <= NO_SIGN;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  sign_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .din   (sign_to_ascii(sign_value)),
    .pop   (pop),
    .dout  (char_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign char_valid = !empty;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sign_text_emitter.sv
// Self-checking bench: run-length reference model plus
// directed scenarios and randomized frames.
module tb_sign_text_emitter;

  localparam int SF    = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sign_value = 4'h0;
  logic       sign_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  sign_text_emitter #(
    .STABLE_FRAMES (SF),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sign_value (sign_value),
    .sign_valid (sign_valid),
    .clear      (clear),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference model: a sign commits when its current run
  // reaches exactly SF frames
  int       m_run_val;
  int       m_run_len;
  int       m_last;
  bit       m_ovf;
  byte      m_q[$];

  function automatic byte to_ascii(input int s);
    if (s < 10) return byte'(8'h30 + s);
    return byte'(8'h41 + s - 10);
  endfunction

  task automatic model_reset();
    m_run_val = 15;
    m_run_len = 0;
    m_last    = 15;
    m_ovf     = 1'b0;
    m_q.delete();
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      model_reset();
    end else begin
      bit pop_now;
      bit was_full;
      bit push_now;
      int v;
      pop_now  = (m_q.size() > 0) && char_ready;
      was_full = (m_q.size() == DEPTH);
      push_now = 1'b0;
      if (sign_valid) begin
        v = int'(sign_value);
        if (v == m_run_val) m_run_len++;
        else begin
          m_run_val = v;
          m_run_len = 1;
        end
        if (m_run_len == SF) begin
          push_now = (v != 15) && (v != m_last);
          m_last = v;
        end
      end
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        if (!was_full || pop_now) m_q.push_back(to_ascii(v));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("char_valid", 32'(char_valid),
            32'(m_q.size() > 0));
      check("fifo_count", 32'(fifo_count),
            32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0)
        check("char_data", 32'(char_data),
              32'(m_q[0]));
    end
  end

  task automatic frame(input logic [3:0] v);
    sign_value = v;
    sign_valid = 1'b1;
    @(negedge clk);
    sign_valid = 1'b0;
  endtask

  task automatic frames(input logic [3:0] v,
                        input int n);
    for (int i = 0; i < n; i++) frame(v);
  endtask

  task automatic drain();
    char_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (fifo_count == 0) break;
      @(negedge clk);
    end
    char_ready = 1'b0;
    check("drain_empty", 32'(char_valid), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_data", 32'(char_data), 32'h00);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ovf", 32'(overflow), 32'd0);

    // four frames of 3 commit one '3', later frames hold
    frames(4'd3, 3);
    check("pre_commit", 32'(fifo_count), 32'd0);
    frame(4'd3);
    check("t1_valid", 32'(char_valid), 32'd1);
    check("t1_data", 32'(char_data), 32'h33);
    frames(4'd3, 6);
    check("t1_norepeat", 32'(fifo_count), 32'd1);
    drain();

    // interrupted run does not commit
    frames(4'd5, 3);
    frame(4'd7);
    frames(4'd5, 3);
    check("t2_pending", 32'(fifo_count), 32'd0);
    frame(4'd5);
    check("t2_count", 32'(fifo_count), 32'd1);
    check("t2_data", 32'(char_data), 32'h35);
    drain();

    // NO_SIGN re-arms; a plain interruption does not
    frames(4'd12, 4);
    frames(4'hF, 4);
    frames(4'd12, 4);
    check("t3_rearm", 32'(fifo_count), 32'd2);
    check("t3_data", 32'(char_data), 32'h43);
    frames(4'd1, 2);
    frames(4'd12, 4);
    check("t3_suppress", 32'(fifo_count), 32'd2);
    drain();

    // overflow: nine signs into eight slots
    for (int s = 0; s < 9; s++) frames(4'(s), 4);
    check("t4_count", 32'(fifo_count), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd1);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_order", 32'(char_data), 32'(8'h30 + i));
      @(negedge clk);
    end
    char_ready = 1'b0;
    check("t4_empty", 32'(char_valid), 32'd0);
    check("t4_ovf_hold", 32'(overflow), 32'd1);

    // full FIFO with a pop in the commit cycle
    do_clear();
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int s = 0; s < 8; s++) frames(4'(s), 4);
    check("t5_full", 32'(fifo_count), 32'd8);
    frames(4'd9, 3);
    char_ready = 1'b1;
    frame(4'd9);
    char_ready = 1'b0;
    check("t5_count", 32'(fifo_count), 32'd8);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_head", 32'(char_data), 32'h31);

    // async reset mid-TRACK with three buffered
    do_clear();
    frames(4'd1, 4);
    frames(4'd2, 4);
    frames(4'd3, 4);
    frames(4'd4, 2);
    check("t6_count", 32'(fifo_count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(char_valid), 32'd0);
    check("t6_async_count", 32'(fifo_count), 32'd0);
    check("t6_async_data", 32'(char_data), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    frames(4'd3, 3);
    check("t6_fresh", 32'(fifo_count), 32'd0);
    frame(4'd3);
    check("t6_reemit", 32'(char_data), 32'h33);

    // same through the synchronous clear
    frames(4'd4, 4);
    frames(4'd6, 4);
    frames(4'd7, 2);
    check("t7_count", 32'(fifo_count), 32'd3);
    clear = 1'b1;
    #1;
    check("t7_sync_hold", 32'(fifo_count), 32'd3);
    @(negedge clk);
    clear = 1'b0;
    check("t7_cleared", 32'(fifo_count), 32'd0);
    check("t7_data", 32'(char_data), 32'h00);
    frames(4'd6, 3);
    check("t7_fresh", 32'(fifo_count), 32'd0);
    frame(4'd6);
    check("t7_reemit", 32'(char_data), 32'h36);
    drain();

    // randomized frames, gaps and back-pressure
    begin
      logic [3:0] v;
      v = 4'd0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 99) < 30)
          v = 4'($urandom_range(0, 15));
        char_ready = ($urandom_range(0, 99) < 35);
        frame(v);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          char_ready = ($urandom_range(0, 99) < 35);
          @(negedge clk);
        end
        if ($urandom_range(0, 999) == 0) do_clear();
      end
      char_ready = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
